dcpu16_mbus: RTL

- Two-master, one-slave arbiter for the CPU's two memory ports: FBUS (fetch/save, fs_*) and ABUS (operand load, ab_*).
- Both ports share one single-ported memory (mem_*).
- Sits between the CPU top level and the memory model/SRAM controller. It serialises strobe/ack transactions with round-robin fairness and a no-ack watchdog.

---
 rtl/dcpu16_mbus.sv | 79 +++++++
 1 files changed

// File: rtl/dcpu16_mbus.sv
// dcpu16_mbus: round-robin arbiter that serialises the FBUS and ABUS ports onto one memory, with a no-ack watchdog
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   fs_adr/dto/stb/wre (in)  FBUS request; fs_dti/fs_ack (out) FBUS read data and completion
//   ab_adr/dto/stb/wre (in)  ABUS request; ab_dti/ab_ack (out) ABUS read data and completion
//   mem_adr/dto/stb/wre(out) shared memory request; mem_dti/mem_ack (in) memory data and completion
//   tmo (out)                one-cycle pulse in the cycle after a watchdog abort
module dcpu16_mbus #(
    parameter int TMO = 16,
    parameter int CW  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] fs_adr,
    input  logic [15:0] fs_dto,
    input  logic        fs_stb,
    input  logic        fs_wre,
    output logic [15:0] fs_dti,
    output logic        fs_ack,
    input  logic [15:0] ab_adr,
    input  logic [15:0] ab_dto,
    input  logic        ab_stb,
    input  logic        ab_wre,
    output logic [15:0] ab_dti,
    output logic        ab_ack,
    output logic [15:0] mem_adr,
    output logic [15:0] mem_dto,
    output logic        mem_stb,
    output logic        mem_wre,
    input  logic [15:0] mem_dti,
    input  logic        mem_ack,
    output logic        tmo
);
    typedef enum logic [1:0] {IDLE, GF, GA} state_t;
    state_t        state_q, state_d;
    logic          last_f_q, last_f_d;
    logic [CW-1:0] wdog_q, wdog_d;
    logic          tmo_q;
    logic          g_stb, expire, done;
    // A real ack at the expiry cycle wins over the abort.
    assign g_stb  = (state_q == GF) ? fs_stb : (state_q == GA) ? ab_stb : 1'b0;
    assign expire = g_stb && !mem_ack && (wdog_q == CW'(TMO - 1));
    assign done   = g_stb && (mem_ack || expire);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            last_f_q <= 1'b0;
            wdog_q   <= '0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_f_q <= last_f_d;
            wdog_q   <= wdog_d;
            tmo_q    <= expire;
        end
    end
    // A granted port that drops stb without an ack falls back to IDLE; on completion
    // the finishing master loses any tie so the other port is served without a bubble.
    always_comb begin
        state_d  = (state_q == IDLE) ? ((fs_stb && ab_stb) ? (last_f_q ? GA : GF) : fs_stb ? GF : ab_stb ? GA : IDLE)
                 : !g_stb ? IDLE
                 : !done ? state_q
                 : (state_q == GF) ? (ab_stb ? GA : GF)
                 : (fs_stb ? GF : GA);
        last_f_d = done ? (state_q == GF) : last_f_q;
        wdog_d   = (!g_stb || done) ? '0 : wdog_q + CW'(1);
    end
    always_comb begin
        mem_adr = (state_q == GF) ? fs_adr : (state_q == GA) ? ab_adr : 16'h0000;
        mem_dto = (state_q == GF) ? fs_dto : (state_q == GA) ? ab_dto : 16'h0000;
        mem_wre = (state_q == GF) ? fs_wre : (state_q == GA) ? ab_wre : 1'b0;
        mem_stb = g_stb && !expire;
        fs_ack  = done && (state_q == GF);
        ab_ack  = done && (state_q == GA);
        fs_dti  = (expire && state_q == GF) ? 16'h0000 : mem_dti;
        ab_dti  = (expire && state_q == GA) ? 16'h0000 : mem_dti;
        tmo     = tmo_q;
    end
endmodule
